// File: rtl/button_pulse_pkg.sv
// Shared encodings and helpers for the push-button front end.
package button_pulse_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_e;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_WAIT   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic rise_enabled(input edge_mode_e m);
        return (m == EDGE_RISE) || (m == EDGE_BOTH);
    endfunction

    function automatic logic fall_enabled(input edge_mode_e m);
        return (m == EDGE_FALL) || (m == EDGE_BOTH);
    endfunction

    // Auto-repeat is a stream of press events, so it follows the rise setting.
    function automatic logic repeat_enabled(input edge_mode_e m);
        return rise_enabled(m);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, tick-paced debouncer,
// edge detector and hold-to-repeat FSM feeding a registered pulse.
module button_channel
    import button_pulse_pkg::*;
#(
    parameter int DEB_SAMPLES  = 4,
    parameter int REPEAT_DELAY = 250,
    parameter int REPEAT_RATE  = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_raw,
    input  logic [1:0] edge_mode,
    input  logic       repeat_en,
    output logic       btn_level,
    output logic       btn_pulse
);

    localparam int DEB_W   = cnt_width(DEB_SAMPLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_SAMPLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    edge_mode_e mode;
    assign mode = edge_mode_e'(edge_mode);

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       btn_synced;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    assign btn_synced = sync_q[1];

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    logic             level_q;
    logic             level_d;
    logic [DEB_W-1:0] deb_cnt_q;
    logic [DEB_W-1:0] deb_cnt_d;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case can leave it unassigned and infer a latch.
    always_comb begin
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        if (tick) begin
            if (btn_synced != level_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    level_d   = ~level_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end else begin
                deb_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q   <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    logic level_rise;
    assign level_rise = level_d & ~level_q;

    // ------------------------------------------------------------------
    // Hold-to-repeat FSM; decisions are taken on the same edge the level moves
    // ------------------------------------------------------------------
    rpt_state_e       rpt_state_q;
    rpt_state_e       rpt_state_d;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_d;
    logic             rpt_fire;

    always_comb begin
        rpt_state_d = rpt_state_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_fire    = 1'b0;
        if (!level_d || !repeat_en) begin
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = '0;
        end else begin
            case (rpt_state_q)
                RPT_IDLE: begin
                    if (level_rise) begin
                        rpt_state_d = RPT_WAIT;
                        rpt_cnt_d   = '0;
                    end
                end
                RPT_WAIT: begin
                    if (tick) begin
                        if (rpt_cnt_q == DELAY_LAST) begin
                            rpt_fire    = 1'b1;
                            rpt_state_d = RPT_REPEAT;
                            rpt_cnt_d   = '0;
                        end else if (rpt_cnt_q != '1) begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end
                end
                RPT_REPEAT: begin
                    if (tick) begin
                        if (rpt_cnt_q == RATE_LAST) begin
                            rpt_fire  = 1'b1;
                            rpt_cnt_d = '0;
                        end else if (rpt_cnt_q != '1) begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end
                end
                default: begin
                    rpt_state_d = RPT_IDLE;
                    rpt_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_state_q <= RPT_IDLE;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Pulse output: events land one clk after the edge that decided them
    // ------------------------------------------------------------------
    logic level_prev_q;
    logic rep_pend_q;
    logic pulse_q;
    logic edge_hit;
    logic rep_hit;

    assign edge_hit = (level_q & ~level_prev_q & rise_enabled(mode))
                    | (~level_q & level_prev_q & fall_enabled(mode));
    // Re-qualify a pending repeat so a drop of enable or level kills it at once.
    assign rep_hit  = rep_pend_q & level_q & repeat_en & repeat_enabled(mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_prev_q <= 1'b0;
            rep_pend_q   <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            level_prev_q <= level_q;
            rep_pend_q   <= rpt_fire;
            pulse_q      <= (edge_hit | rep_hit) & ~pulse_q;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: rtl/button_pulse_gen.sv
// N-channel push-button front end: shared sample-tick prescaler driving
// one debounce/edge/repeat channel per button.
module button_pulse_gen
    import button_pulse_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DIV          = 4,
    parameter int DEB_SAMPLES  = 4,
    parameter int REPEAT_DELAY = 250,
    parameter int REPEAT_RATE  = 50
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_raw,
    input  logic [1:0]      edge_mode,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_pulse
);

    localparam int DIV_W = cnt_width(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic             tick;

    // With DIV=1 the counter sits at zero and tick stays high.
    assign tick = (div_cnt_q == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        button_channel #(
            .DEB_SAMPLES  (DEB_SAMPLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_channel (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .btn_raw   (btn_raw[g]),
            .edge_mode (edge_mode),
            .repeat_en (repeat_en[g]),
            .btn_level (btn_level[g]),
            .btn_pulse (btn_pulse[g])
        );
    end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Randomized bench for button_pulse_gen: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the button rules.
module tb_button_pulse_gen;

    localparam int N_CH = 4;
    localparam int DIV  = 4;
    localparam int DEB  = 4;
    localparam int RD   = 8;
    localparam int RR   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N_CH-1:0] btn_raw;
    logic [1:0]      edge_mode;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_pulse;

    button_pulse_gen #(
        .N_CH         (N_CH),
        .DIV          (DIV),
        .DEB_SAMPLES  (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .edge_mode (edge_mode),
        .repeat_en (repeat_en),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int tb_cyc   = 0;
    int pt[N_CH][$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, tb_cyc);
    endtask

    // ---------------- behavioural model ----------------
    int              m_cyc;
    logic [N_CH-1:0] m_raw_d1, m_raw_d2;
    logic [N_CH-1:0] m_level, m_pulse;
    int              m_run[N_CH];
    bit              m_rose[N_CH], m_fell[N_CH], m_rep[N_CH], m_armed[N_CH];
    int              m_held[N_CH];

    task automatic model_reset();
        m_cyc = 0; m_raw_d1 = '0; m_raw_d2 = '0; m_level = '0; m_pulse = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_run[i] = 0; m_rose[i] = 0; m_fell[i] = 0; m_rep[i] = 0;
            m_armed[i] = 0; m_held[i] = 0;
        end
    endtask

    task automatic model_step();
        bit tick, want, new_lvl, rise, fire, rise_ok, fall_ok;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick    = (m_cyc % DIV) == (DIV - 1);
        rise_ok = (edge_mode == 2'b00) || (edge_mode == 2'b10);
        fall_ok = (edge_mode == 2'b01) || (edge_mode == 2'b10);
        for (int i = 0; i < N_CH; i++) begin
            // events decided on the previous edge show up now
            want = (m_rose[i] && rise_ok) || (m_fell[i] && fall_ok)
                 || (m_rep[i] && repeat_en[i] && m_level[i] && rise_ok);
            // level flips after DEB consecutive ticks of disagreement
            new_lvl = m_level[i];
            if (tick) begin
                if (m_raw_d2[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        new_lvl  = !m_level[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            rise = new_lvl && !m_level[i];
            // repeat: pulse at RD ticks of hold, then every RR ticks
            fire = 0;
            if (!new_lvl || !repeat_en[i]) begin
                m_armed[i] = 0;
            end else if (rise) begin
                m_armed[i] = 1;
                m_held[i]  = 0;
            end else if (m_armed[i] && tick) begin
                m_held[i]++;
                fire = (m_held[i] == RD) || (m_held[i] > RD && ((m_held[i] - RD) % RR) == 0);
            end
            m_rose[i]  = rise;
            m_fell[i]  = !new_lvl && m_level[i];
            m_rep[i]   = fire;
            m_pulse[i] = want && !m_pulse[i];
            m_level[i] = new_lvl;
        end
        m_raw_d2 = m_raw_d1;
        m_raw_d1 = btn_raw;
        m_cyc++;
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        tb_cyc++;
        model_step();
        @(negedge clk);
        check("level", 32'(btn_level), 32'(m_level));
        check("pulse", 32'(btn_pulse), 32'(m_pulse));
        for (int i = 0; i < N_CH; i++) if (btn_pulse[i]) pt[i].push_back(tb_cyc);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    function automatic int count_after(input int ch, input int t0);
        int c = 0;
        foreach (pt[ch][j]) if (pt[ch][j] > t0) c++;
        return c;
    endfunction

    int k, t, lat, nz;
    logic [N_CH-1:0] seen;

    initial begin
        btn_raw = '0; repeat_en = '0; edge_mode = 2'b00; rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("reset_level", 32'(btn_level), 32'h0);
        check("reset_pulse", 32'(btn_pulse), 32'h0);
        run(3);
        rst_n = 1'b1;
        run(5);

        // 1: clean press on ch0
        run($urandom_range(0, 3));
        pt[0].delete();
        btn_raw[0] = 1'b1; k = tb_cyc;
        run(100);
        check("t1_pulse_count", pt[0].size(), 1);
        if (pt[0].size() > 0) begin
            lat = pt[0][0] - k;
            check("t1_latency_15_19", 32'(lat >= 15 && lat <= 19), 1);
        end
        check("t1_level_high", 32'(btn_level[0]), 1);
        btn_raw[0] = 1'b0; pt[0].delete();
        run(40);
        check("t1_no_release_pulse", pt[0].size(), 0);

        // 2: glitch shorter than the debounce window, then bouncing
        pt[1].delete();
        btn_raw[1] = 1'b1; run(12);
        btn_raw[1] = 1'b0; run(30);
        check("t2_glitch_pulses", pt[1].size(), 0);
        for (int b = 0; b < 10; b++) begin
            btn_raw[1] = 1'b1; run(2);
            btn_raw[1] = 1'b0; run(2);
        end
        btn_raw[1] = 1'b1; run(40);
        check("t2_bounce_pulses", pt[1].size(), 1);
        btn_raw[1] = 1'b0; run(30);

        // 3: edge modes on ch2
        for (int m = 1; m < 4; m++) begin
            edge_mode = 2'(m); pt[2].delete();
            btn_raw[2] = 1'b1; run(40);
            if (m == 1) check("t3_fall_none_on_press", pt[2].size(), 0);
            btn_raw[2] = 1'b0; run(40);
            check($sformatf("t3_mode%0d_pulses", m), pt[2].size(), (m == 1) ? 1 : (m == 2) ? 2 : 0);
        end
        edge_mode = 2'b00;

        // 4: auto-repeat on ch0
        repeat_en[0] = 1'b1; pt[0].delete();
        btn_raw[0] = 1'b1; k = tb_cyc;
        run(200);
        check("t4_enough_pulses", 32'(pt[0].size() >= 5), 1);
        if (pt[0].size() >= 2) check("t4_first_gap", pt[0][1] - pt[0][0], 32);
        for (int j = 2; j < pt[0].size(); j++) check("t4_rate_gap", pt[0][j] - pt[0][j-1], 16);
        repeat_en[0] = 1'b0; t = tb_cyc;
        run(40);
        check("t4_disable_stops", count_after(0, t), 0);
        btn_raw[0] = 1'b0; run(30);
        repeat_en[0] = 1'b1; btn_raw[0] = 1'b1; run(60);
        btn_raw[0] = 1'b0; t = tb_cyc;
        run(80);
        check("t4_release_stops", count_after(0, t + 21), 0);
        repeat_en[0] = 1'b0;

        // 5: reset in the middle of a hold
        btn_raw[3] = 1'b1; run(40);
        check("t5_level_before", 32'(btn_level[3]), 1);
        rst_n = 1'b0;
        #1;
        check("t5_async_level", 32'(btn_level), 32'h0);
        check("t5_async_pulse", 32'(btn_pulse), 32'h0);
        run(3);
        rst_n = 1'b1; pt[3].delete();
        run(40);
        check("t5_single_rise", pt[3].size(), 1);
        btn_raw[3] = 1'b0; run(30);

        // 6: all channels pressed on the same clock
        btn_raw = '1; nz = 0; seen = '0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (btn_pulse != '0) begin nz++; seen = btn_pulse; end
        end
        check("t6_pulse_cycles", nz, 1);
        check("t6_pulse_vector", 32'(seen), 32'hF);
        btn_raw = '0; run(30);

        // 7: random traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 11) == 0) btn_raw[i] = ~btn_raw[i];
                if ($urandom_range(0, 59) == 0) repeat_en[i] = ~repeat_en[i];
            end
            if ($urandom_range(0, 99) == 0) edge_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; run(2); rst_n = 1'b1;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
